laser_frame_transmitter: RTL and testbench
==========================================

Name: laser_frame_transmitter

Overview:
- Downstream serializer of the echo/transmit controller.
- Accepts one byte per `data_ready` strobe and emits it on the laser as a framed, fixed-rate serial bit stream: preamble, start, 8 data bits LSB-first, even parity, stop.
- Pulses `done` once per completed frame so the controller can leave its wait-for-transmission state.
- Runs on the system clock and uses an internal bit-period counter instead of a divided clock.

Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per transmitted bit; must be ≥2.
- `PREAMBLE_BITS`, 4: number of alternating 1/0 preamble bits; must be ≥2 and even.

Ports:
- `clock` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `en` input 1: permits acceptance of a new byte; does not affect a frame in progress.
- `data_transmit` input 8: byte to send; sampled only on the acceptance cycle.
- `data_ready` input 1: request to send; level-sensitive, and may be held high.
- `laser_out` output 2: [1] = serial data bit; [0] = frame-active (high for every bit of a frame).
- `done` output 1: one-cycle pulse at end of each frame.
- `busy` output 1: high from acceptance until frame end.

Behaviour:
- **Outputs:** all are registered. Reset drives `laser_out`=2'b00, `done`=0, `busy`=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
- **States:** IDLE, PREAMBLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `laser_out`=00, `busy`=0.
  - If `en` & `data_ready` at a rising edge:
    - Latch `data_transmit` into the shift register.
    - Compute parity = XOR of the 8 bits.
    - Enter PREAMBLE, set `busy`=1, clear the counters.
  - First preamble bit appears on `laser_out` the cycle after acceptance (latency 1).
- **Bit timing:** each bit state holds `laser_out` constant for exactly `CLKS_PER_BIT` cycles. The cycle counter runs 0..`CLKS_PER_BIT`-1; at terminal count it advances the bit or state.
- **PREAMBLE:** `PREAMBLE_BITS` bits, alternating and starting with 1 (1,0,1,0…), then go to START.
- **START:** one bit of value 1, then go to DATA.
- **DATA:** 8 bits, `data[0]` first; the shift register shifts right at each bit boundary. After bit 7, go to PARITY.
- **PARITY:** one bit = even parity, so the total ones over data plus parity is even. Then go to STOP.
- **STOP:** one bit of value 0 with `laser_out[0]` still 1. At its terminal count:
  - Return to IDLE.
  - `done`=1 and `busy`=0 for the next cycle only.
  - `laser_out`=00.
- **Frame length:** exactly (`PREAMBLE_BITS`+11)×`CLKS_PER_BIT` cycles of `laser_out[0]`=1. The default is 240.
- **Back-to-back frames:** in the cycle `done` is high (IDLE), a held `data_ready` & `en` is accepted. The new frame starts on the following cycle, so there is exactly one idle cycle between frames.
- **Ignored inputs:**
  - `data_ready` while `busy` is ignored; requests are not queued.
  - `data_transmit` changes after acceptance have no effect.
- **`en` low:** mid-frame, the frame completes normally and `done` still pulses. In IDLE, no acceptance occurs.
- **Reset mid-frame:** outputs go to 00 immediately (asynchronously); no `done` pulse; the frame is lost.
- **`laser_out[1]` with `laser_out[0]`=0:** always 0.

Test Plan:
- **Reset mid-frame:** reset during DATA bit 3 → `laser_out`=00 the same cycle, `busy`=0, no `done`. After release, a 0x3C request yields a complete correct frame.
- **Single frame, byte 0xA5, defaults:**
  - Pulse `data_ready` for 1 cycle with `en`=1.
  - `laser_out[1]` per 16-cycle bit: 1,0,1,0 | 1 | 1,0,1,0,0,1,0,1 | 0 | 0.
  - `laser_out[0]`=1 for 240 cycles; `done` high for 1 cycle at cycle 241 after acceptance.
- **Parity check, byte 0x07:** 3 ones → parity bit = 1; the data bits are 1,1,1,0,0,0,0,0.
- **Held `data_ready`, constant 0x0A:** two consecutive frames separated by exactly one cycle of `laser_out`=00; `done` pulses once per frame (every 241 cycles).
- **Request ignored while busy:** accept 0x55, then change `data_transmit` to 0xFF and pulse `data_ready` mid-frame → the frame carries 0x55; no second frame starts; `done` pulses once.
- **`en` dropped, then a gated request:** drop `en` during PARITY → the frame finishes and `done` pulses. A `data_ready` presented with `en`=0 afterward → remains IDLE, `busy`=0.

Source files
------------

// File: rtl/laser_frame_transmitter_if.sv
// Handshake and laser bus between the transmit controller and the frame serializer.
// The controller drives the request side; the serializer drives the laser and status.
interface laser_frame_transmitter_if;
    logic       en;
    logic [7:0] data_transmit;
    logic       data_ready;
    logic [1:0] laser_out;
    logic       done;
    logic       busy;

    modport master (
        output en, data_transmit, data_ready,
        input  laser_out, done, busy
    );

    modport slave (
        input  en, data_transmit, data_ready,
        output laser_out, done, busy
    );
endinterface

// File: rtl/laser_frame_transmitter.sv
// Serializes one byte per request into a framed laser bit stream:
// alternating preamble, start, 8 data bits LSB-first, even parity, stop.
module laser_frame_transmitter #(
    parameter int unsigned CLKS_PER_BIT  = 16,
    parameter int unsigned PREAMBLE_BITS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    laser_frame_transmitter_if.slave   bus
);
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned MAXB = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
    localparam int unsigned BW   = $clog2(MAXB);
    localparam logic [CW-1:0] LAST_CYC      = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_PREAMBLE = BW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] LAST_DATA     = BW'(7);

    typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [BW-1:0] bitcnt;
    logic [7:0]    shreg;
    logic          parity;

    // laser_out is loaded with the next bit at each boundary, so the value is
    // already registered when the new bit period begins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cyc        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            bus.laser_out <= 2'b00;
            bus.done   <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.laser_out <= 2'b00;
                    bus.busy      <= 1'b0;
                    cyc           <= '0;
                    bitcnt        <= '0;
                    if (bus.en && bus.data_ready) begin
                        shreg         <= bus.data_transmit;
                        parity        <= ^bus.data_transmit;
                        state         <= PREAMBLE;
                        bus.busy      <= 1'b1;
                        bus.laser_out <= 2'b11;
                    end
                end
                default: begin
                    if (cyc != LAST_CYC) begin
                        cyc <= cyc + 1'b1;
                    end else begin
                        cyc <= '0;
                        case (state)
                            PREAMBLE: begin
                                if (bitcnt == LAST_PREAMBLE) begin
                                    bitcnt        <= '0;
                                    state         <= START;
                                    bus.laser_out <= 2'b11;
                                end else begin
                                    bitcnt        <= bitcnt + 1'b1;
                                    bus.laser_out <= {~bus.laser_out[1], 1'b1};
                                end
                            end
                            START: begin
                                state         <= DATA;
                                bus.laser_out <= {shreg[0], 1'b1};
                            end
                            DATA: begin
                                if (bitcnt == LAST_DATA) begin
                                    bitcnt        <= '0;
                                    state         <= PARITY;
                                    bus.laser_out <= {parity, 1'b1};
                                end else begin
                                    bitcnt        <= bitcnt + 1'b1;
                                    shreg         <= shreg >> 1;
                                    bus.laser_out <= {shreg[1], 1'b1};
                                end
                            end
                            PARITY: begin
                                state         <= STOP;
                                bus.laser_out <= 2'b01;
                            end
                            STOP: begin
                                state         <= IDLE;
                                bus.laser_out <= 2'b00;
                                bus.done      <= 1'b1;
                                bus.busy      <= 1'b0;
                            end
                            default: begin
                                state         <= IDLE;
                                bus.laser_out <= 2'b00;
                                bus.busy      <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_laser_frame_transmitter.sv
// Randomized and directed bench for laser_frame_transmitter against a
// per-cycle reference built from the frame's bit list.
module tb_laser_frame_transmitter;
    localparam int unsigned C     = 16;
    localparam int unsigned P     = 4;
    localparam int unsigned NB    = P + 11;
    localparam int          FRAME = NB * C;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    laser_frame_transmitter_if bus ();

    laser_frame_transmitter #(
        .CLKS_PER_BIT  (C),
        .PREAMBLE_BITS (P)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit i of the result is the i-th bit sent on the laser.
    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
        logic [NB-1:0] f;
        f = '0;
        for (int i = 0; i < P; i++) f[i] = (i % 2 == 0);
        f[P] = 1'b1;
        for (int i = 0; i < 8; i++) f[P+1+i] = b[i];
        f[P+9]  = ($countones(b) % 2) == 1;
        f[P+10] = 1'b0;
        return f;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("idle_lo", 32'(bus.laser_out), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_done", 32'(bus.done), 32'd0);
        end
    endtask

    // Called at a negedge with the DUT able to accept on the coming edge.
    task automatic frame(input logic [7:0] b, input bit keep, input bit noise,
                         input logic [7:0] noise_data, input bit drop_en, input int abort_at);
        logic [NB-1:0] f;
        int nk;
        f  = frame_bits(b);
        nk = int'($urandom_range(FRAME - 4, 2));
        bus.en            = 1'b1;
        bus.data_transmit = b;
        bus.data_ready    = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clock);
            check($sformatf("lo k=%0d", k), 32'(bus.laser_out), 32'({f[k / C], 1'b1}));
            check($sformatf("busy k=%0d", k), 32'(bus.busy), 32'd1);
            check($sformatf("done k=%0d", k), 32'(bus.done), 32'd0);
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check("abort_lo", 32'(bus.laser_out), 32'd0);
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_done", 32'(bus.done), 32'd0);
                return;
            end
            if (!keep) bus.data_ready = 1'b0;
            if (noise && k == nk) begin
                bus.data_transmit = noise_data;
                bus.data_ready    = 1'b1;
            end
            if (drop_en && k == int'((P + 9) * C)) bus.en = 1'b0;
        end
        @(negedge clock);
        check("end_lo", 32'(bus.laser_out), 32'd0);
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_done", 32'(bus.done), 32'd1);
    endtask

    initial begin
        bit keep;
        logic [7:0] b;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.en            = 1'b0;
        bus.data_ready    = 1'b0;
        bus.data_transmit = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("rst_lo", 32'(bus.laser_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        idle(3);

        frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, -1);
        idle(4);
        frame(8'h07, 1'b0, 1'b0, 8'h00, 1'b0, -1);
        idle(2);

        frame(8'h0A, 1'b1, 1'b0, 8'h00, 1'b0, -1);
        frame(8'h0A, 1'b1, 1'b0, 8'h00, 1'b0, -1);
        bus.data_ready = 1'b0;
        idle(3);

        frame(8'h55, 1'b0, 1'b1, 8'hFF, 1'b0, -1);
        idle(5);

        frame(8'hC3, 1'b0, 1'b0, 8'h00, 1'b1, -1);
        bus.data_ready = 1'b1;
        idle(6);
        bus.data_ready = 1'b0;
        bus.en         = 1'b1;
        idle(1);

        frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, int'((P + 4) * C + 3));
        bus.data_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("inrst_lo", 32'(bus.laser_out), 32'd0);
            check("inrst_done", 32'(bus.done), 32'd0);
        end
        reset = 1'b0;
        idle(2);
        frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, -1);
        idle(2);

        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom);
            keep = (n != 11) && ($urandom_range(1, 0) == 1);
            frame(b, keep, $urandom_range(1, 0) == 1, 8'($urandom),
                  $urandom_range(3, 0) == 0, -1);
            if (!keep) begin
                bus.data_ready = 1'b0;
                idle(int'($urandom_range(3, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
